// File: rtl/alu_exec_if.sv
// Bus between the ALU control side and the execute-stage ALU.
// Start is taken on a rising edge only while Busy is low; Done pulses for one
// cycle, and Result/Zero/Illegal hold from that cycle until the next Done.
interface alu_exec_if #(
   parameter int W  = 32,
   parameter int SW = 5
);
   logic          Start;
   logic [3:0]    Operation;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [SW-1:0] Shamt;
   logic [W-1:0]  Result;
   logic          Zero;
   logic          Illegal;
   logic          Busy;
   logic          Done;

   modport master (
      output Start, Operation, A, B, Shamt,
      input  Result, Zero, Illegal, Busy, Done
   );

   modport slave (
      input  Start, Operation, A, B, Shamt,
      output Result, Zero, Illegal, Busy, Done
   );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: one-cycle logic/arithmetic ops, bit-serial shifts
// (one position per cycle) behind a Start/Busy/Done handshake.
module alu_exec #(
   parameter int W  = 32,
   parameter int SW = 5
) (
   input  logic       clk,
   input  logic       rst,
   alu_exec_if.slave  bus,
   output logic       dbg_state_o
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic {IDLE, SHIFT} state_t;
   typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

   state_t        state_q;
   kind_t         kind_q;
   logic [SW-1:0] cnt_q;
   logic [W-1:0]  shreg_q;
   logic [W-1:0]  result_q;
   logic          zero_q;
   logic          illegal_q;
   logic          done_q;

   logic [W-1:0]  alu_res_d;
   logic          legal_d;
   logic          is_shift_d;
   kind_t         kind_d;
   logic [W-1:0]  shift_nxt_d;

   // Decode and single-cycle datapath; for shifts alu_res_d is A (the Shamt=0 result).
   always_comb begin
      alu_res_d  = '0;
      legal_d    = 1'b1;
      is_shift_d = 1'b0;
      kind_d     = K_SLL;
      case (bus.Operation)
         OP_AND: alu_res_d = bus.A & bus.B;
         OP_OR:  alu_res_d = bus.A | bus.B;
         OP_ADD: alu_res_d = bus.A + bus.B;
         OP_SUB: alu_res_d = bus.A - bus.B;
         OP_SLT: alu_res_d = {{(W-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_NOR: alu_res_d = ~(bus.A | bus.B);
         OP_SLL: begin is_shift_d = 1'b1; kind_d = K_SLL; alu_res_d = bus.A; end
         OP_SRL: begin is_shift_d = 1'b1; kind_d = K_SRL; alu_res_d = bus.A; end
         OP_SRA: begin is_shift_d = 1'b1; kind_d = K_SRA; alu_res_d = bus.A; end
         default: legal_d = 1'b0;
      endcase
   end

   always_comb begin
      shift_nxt_d = {shreg_q[W-2:0], 1'b0};
      case (kind_q)
         K_SRL:   shift_nxt_d = {1'b0, shreg_q[W-1:1]};
         K_SRA:   shift_nxt_d = {shreg_q[W-1], shreg_q[W-1:1]};
         default: shift_nxt_d = {shreg_q[W-2:0], 1'b0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         kind_q    <= K_SLL;
         cnt_q     <= '0;
         shreg_q   <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.Start) begin
                  if (is_shift_d && (bus.Shamt != '0)) begin
                     shreg_q <= bus.A;
                     cnt_q   <= bus.Shamt;
                     kind_q  <= kind_d;
                     state_q <= SHIFT;
                  end else if (!legal_d) begin
                     result_q  <= '0;
                     zero_q    <= 1'b1;
                     illegal_q <= 1'b1;
                     done_q    <= 1'b1;
                  end else begin
                     result_q  <= alu_res_d;
                     zero_q    <= (alu_res_d == '0);
                     illegal_q <= 1'b0;
                     done_q    <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               shreg_q <= shift_nxt_d;
               cnt_q   <= cnt_q - SW'(1);
               if (cnt_q == SW'(1)) begin
                  result_q  <= shift_nxt_d;
                  zero_q    <= (shift_nxt_d == '0);
                  illegal_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Result  = result_q;
   assign bus.Zero    = zero_q;
   assign bus.Illegal = illegal_q;
   assign bus.Busy    = (state_q == SHIFT);
   assign bus.Done    = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vectors, a cycle-level reference model of the
// handshake and results, and hand-computed literal expectations.
module tb_alu_exec;
   localparam int W  = 32;
   localparam int SW = 5;

   logic clk = 1'b0;
   logic rst;
   logic dbg_state;
   int   total = 0;
   int   bad   = 0;

   alu_exec_if #(.W(W), .SW(SW)) bus ();

   alu_exec #(.W(W), .SW(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: results from plain arithmetic, timing as a countdown of busy cycles.
   bit           model_live = 0;
   int           m_busy_left;
   bit           m_done;
   logic [W-1:0] m_res, p_res;
   bit           m_zero, m_ill;

   function automatic logic [W:0] model_op(input logic [3:0] op, input logic [W-1:0] a, b,
                                           input logic [SW-1:0] sh);
      logic [W-1:0] r;
      logic         il;
      r  = '0;
      il = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
         4'b1100: r = ~(a | b);
         4'b0011: r = a << sh;
         4'b0100: r = a >> sh;
         4'b0101: r = $signed(a) >>> sh;
         default: il = 1'b1;
      endcase
      return {il, r};
   endfunction

   always @(posedge clk) begin
      logic [W:0] mo;
      bit         shift_op;
      model_live = 1;
      if (rst) begin
         m_busy_left = 0;
         m_done      = 0;
         m_res       = '0;
         m_zero      = 1;
         m_ill       = 0;
      end else begin
         m_done = 0;
         if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
               m_done = 1;
               m_res  = p_res;
               m_zero = (p_res == '0);
               m_ill  = 0;
            end
         end else if (bus.Start) begin
            mo       = model_op(bus.Operation, bus.A, bus.B, bus.Shamt);
            shift_op = (bus.Operation inside {4'b0011, 4'b0100, 4'b0101});
            if (shift_op && bus.Shamt != '0) begin
               m_busy_left = int'(bus.Shamt);
               p_res       = mo[W-1:0];
            end else begin
               m_done = 1;
               m_res  = mo[W-1:0];
               m_zero = (mo[W-1:0] == '0);
               m_ill  = mo[W];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("busy",    W'(bus.Busy),    W'(m_busy_left > 0));
         check("state",   W'(dbg_state),   W'(m_busy_left > 0));
         check("done",    W'(bus.Done),    W'(m_done));
         check("result",  bus.Result,      m_res);
         check("zero",    W'(bus.Zero),    W'(m_zero));
         check("illegal", W'(bus.Illegal), W'(m_ill));
      end
   end

   // Called at a negedge (cycle 0); waits a bounded time for Done and checks literals.
   task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a, b,
                         input logic [SW-1:0] sh, input logic [W-1:0] exp_r,
                         input bit exp_z, input bit exp_il, input int exp_lat);
      int k;
      bit seen;
      bus.Operation = op;
      bus.A         = a;
      bus.B         = b;
      bus.Shamt     = sh;
      bus.Start     = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      k    = 1;
      seen = 0;
      while (!seen && k <= W + 4) begin
         if (bus.Done) seen = 1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check({name, "_done_seen"}, W'(seen), W'(1));
      check({name, "_latency"},   W'(k),    W'(exp_lat));
      check({name, "_result"},    bus.Result,       exp_r);
      check({name, "_zero"},      W'(bus.Zero),     W'(exp_z));
      check({name, "_illegal"},   W'(bus.Illegal),  W'(exp_il));
      @(negedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      bus.Start     = 1'b1;
      bus.Operation = 4'b0010;
      bus.A         = 32'd1;
      bus.B         = 32'd1;
      bus.Shamt     = '0;
      repeat (3) @(negedge clk);
      check("rst_done",    W'(bus.Done),    W'(0));
      check("rst_busy",    W'(bus.Busy),    W'(0));
      check("rst_result",  bus.Result,      32'h0);
      check("rst_zero",    W'(bus.Zero),    W'(1));
      check("rst_illegal", W'(bus.Illegal), W'(0));
      bus.Start = 1'b0;
      rst       = 1'b0;
      @(negedge clk);

      run_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 0, 1);
      run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0, 32'h0, 1, 0, 1);
      run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0, 0, 1);
      run_op("nor_zero", 4'b1100, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0, 1);
      run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200, 0, 0, 1);
      run_op("or",       4'b0001, 32'hA000_0001, 32'h0500_0010, 0, 32'hA500_0011, 0, 0, 1);

      // SRA with an ignored Start mid-shift and a back-to-back Start on Done.
      bus.Operation = 4'b0101;
      bus.A         = 32'h8000_0000;
      bus.Shamt     = 5'd4;
      bus.Start     = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      check("sra_busy_c1", W'(bus.Busy), W'(1));
      @(negedge clk);
      bus.Operation = 4'b0010;
      bus.A         = 32'd1;
      bus.B         = 32'd1;
      bus.Start     = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      check("sra_nodone_c3", W'(bus.Done), W'(0));
      @(negedge clk);
      check("sra_busy_c4", W'(bus.Busy), W'(1));
      @(negedge clk);
      check("sra_done_c5",  W'(bus.Done), W'(1));
      check("sra_busy_c5",  W'(bus.Busy), W'(0));
      check("sra_result",   bus.Result,   32'hF800_0000);
      bus.Operation = 4'b0011;
      bus.A         = 32'd1;
      bus.Shamt     = 5'd0;
      bus.Start     = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      check("b2b_done_c6", W'(bus.Done), W'(1));
      check("b2b_result",  bus.Result,   32'h1);
      @(negedge clk);

      run_op("illegal",     4'b1111, 32'd3, 32'd3, 0, 32'h0, 1, 1, 1);
      run_op("clear_ill",   4'b0000, 32'd3, 32'd3, 0, 32'h3, 0, 0, 1);
      run_op("sll_max",     4'b0011, 32'h1, 32'h0, 5'd31, 32'h8000_0000, 0, 0, 32);
      run_op("srl_3",       4'b0100, 32'hF0, 32'h0, 5'd3, 32'h1E, 0, 0, 4);
      run_op("srl_to_zero", 4'b0100, 32'h1, 32'h0, 5'd1, 32'h0, 1, 0, 2);

      // Reset aborts a long shift; no Done follows.
      bus.Operation = 4'b0100;
      bus.A         = 32'hF0;
      bus.Shamt     = 5'd31;
      bus.Start     = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",   W'(bus.Busy), W'(0));
      check("abort_done",   W'(bus.Done), W'(0));
      check("abort_result", bus.Result,   32'h0);
      @(negedge clk);
      check("abort_nodone", W'(bus.Done), W'(0));
      run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 0, 32'd5, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
